// File: rtl/ahb_rr_arbiter.sv
// Two-master AHB arbiter onto one slave port.
// Round-robin or fixed priority, one pending request per master.
module ahb_rr_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel_m0,
  input  logic        hsel_m1,
  input  logic [31:0] hmaster_m0,
  input  logic [31:0] hmaster_m1,
  input  logic [31:0] haddr_m0,
  input  logic [31:0] haddr_m1,
  input  logic [2:0]  hsize_m0,
  input  logic [2:0]  hsize_m1,
  input  logic        hwrite_m0,
  input  logic        hwrite_m1,
  input  logic [31:0] hwdata_m0,
  input  logic [31:0] hwdata_m1,
  output logic [31:0] hrdata_m0,
  output logic [31:0] hrdata_m1,
  output logic        hready_m0,
  output logic        hready_m1,
  output logic        hresp_m0,
  output logic        hresp_m1,
  output logic        hsel_s,
  output logic [31:0] hmaster_s,
  output logic [31:0] haddr_s,
  output logic [2:0]  hsize_s,
  output logic        hwrite_s,
  output logic [31:0] hwdata_s,
  input  logic [31:0] hrdata_s,
  input  logic        hready_s,
  input  logic        hresp_s,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [31:0] master;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
  } req_t;

  state_t     state;
  logic [1:0] gnt;
  logic [1:0] pend;
  logic       last_m1;
  req_t       buf0;
  req_t       buf1;
  req_t       cur;

  logic       in_data;
  logic [1:0] cap;
  logic [1:0] done;
  logic [1:0] pend_n;
  logic [1:0] win;

  assign grant   = gnt;
  assign in_data = (state == DATA);

  always_comb begin
    hready_m0 = (in_data && gnt[0]) ? hready_s : !pend[0];
    hready_m1 = (in_data && gnt[1]) ? hready_s : !pend[1];
    hresp_m0  = in_data && gnt[0] && hresp_s;
    hresp_m1  = in_data && gnt[1] && hresp_s;
    hrdata_m0 = (in_data && gnt[0]) ? hrdata_s : 32'h0;
    hrdata_m1 = (in_data && gnt[1]) ? hrdata_s : 32'h0;
  end

  // A completing master may re-request in the same cycle.
  always_comb begin
    cap    = {hsel_m1 & hready_m1, hsel_m0 & hready_m0};
    done   = (in_data && hready_s) ? gnt : 2'b00;
    pend_n = cap | (pend & ~done);
    win    = pend_n;
    if (&pend_n) begin
      if (RR_EN) win = last_m1 ? 2'b01 : 2'b10;
      else       win = 2'b01;
    end
  end

  always_comb begin
    cur = '0;
    unique case (1'b1)
      gnt[0]:  cur = buf0;
      gnt[1]:  cur = buf1;
      default: cur = '0;
    endcase
  end

  always_comb begin
    hsel_s    = (state == ADDR);
    hmaster_s = cur.master;
    haddr_s   = cur.addr;
    hsize_s   = cur.size;
    hwrite_s  = cur.write;
    hwdata_s  = 32'h0;
    if (in_data) hwdata_s = gnt[1] ? hwdata_m1 : hwdata_m0;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      pend    <= 2'b00;
      last_m1 <= 1'b0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      pend <= pend_n;
      if (cap[0]) buf0 <= {hmaster_m0, haddr_m0, hsize_m0, hwrite_m0};
      if (cap[1]) buf1 <= {hmaster_m1, haddr_m1, hsize_m1, hwrite_m1};
      unique case (state)
        IDLE: begin
          if (|pend_n) begin
            state   <= ADDR;
            gnt     <= win;
            last_m1 <= win[1];
          end
        end
        ADDR: state <= DATA;
        DATA: begin
          if (hready_s) begin
            if (|(pend_n & ~gnt)) begin
              state   <= ADDR;
              gnt     <= ~gnt;
              last_m1 <= gnt[0];
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter.
// Round-robin and fixed-priority instances share stimulus.
module tb_ahb_rr_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel_m0, hsel_m1;
  logic [31:0] hmaster_m0, hmaster_m1;
  logic [31:0] haddr_m0, haddr_m1;
  logic [2:0]  hsize_m0, hsize_m1;
  logic        hwrite_m0, hwrite_m1;
  logic [31:0] hwdata_m0, hwdata_m1;
  logic [31:0] hrdata_s;
  logic        hready_s, hresp_s;

  logic [31:0] hrdata_m0, hrdata_m1;
  logic        hready_m0, hready_m1, hresp_m0, hresp_m1;
  logic        hsel_s, hwrite_s;
  logic [31:0] hmaster_s, haddr_s, hwdata_s;
  logic [2:0]  hsize_s;
  logic [1:0]  grant;

  logic [31:0] hrdata_m0_f, hrdata_m1_f;
  logic        hready_m0_f, hready_m1_f, hresp_m0_f, hresp_m1_f;
  logic        hsel_s_f, hwrite_s_f;
  logic [31:0] hmaster_s_f, haddr_s_f, hwdata_s_f;
  logic [2:0]  hsize_s_f;
  logic [1:0]  grant_f;

  int checks = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_rr_arbiter #(.RR_EN(1'b1)) u_rr (
    .hclk(hclk), .hresetn(hresetn),
    .hsel_m0(hsel_m0), .hsel_m1(hsel_m1),
    .hmaster_m0(hmaster_m0), .hmaster_m1(hmaster_m1),
    .haddr_m0(haddr_m0), .haddr_m1(haddr_m1),
    .hsize_m0(hsize_m0), .hsize_m1(hsize_m1),
    .hwrite_m0(hwrite_m0), .hwrite_m1(hwrite_m1),
    .hwdata_m0(hwdata_m0), .hwdata_m1(hwdata_m1),
    .hrdata_m0(hrdata_m0), .hrdata_m1(hrdata_m1),
    .hready_m0(hready_m0), .hready_m1(hready_m1),
    .hresp_m0(hresp_m0), .hresp_m1(hresp_m1),
    .hsel_s(hsel_s), .hmaster_s(hmaster_s),
    .haddr_s(haddr_s), .hsize_s(hsize_s),
    .hwrite_s(hwrite_s), .hwdata_s(hwdata_s),
    .hrdata_s(hrdata_s), .hready_s(hready_s),
    .hresp_s(hresp_s), .grant(grant)
  );

  ahb_rr_arbiter #(.RR_EN(1'b0)) u_fp (
    .hclk(hclk), .hresetn(hresetn),
    .hsel_m0(hsel_m0), .hsel_m1(hsel_m1),
    .hmaster_m0(hmaster_m0), .hmaster_m1(hmaster_m1),
    .haddr_m0(haddr_m0), .haddr_m1(haddr_m1),
    .hsize_m0(hsize_m0), .hsize_m1(hsize_m1),
    .hwrite_m0(hwrite_m0), .hwrite_m1(hwrite_m1),
    .hwdata_m0(hwdata_m0), .hwdata_m1(hwdata_m1),
    .hrdata_m0(hrdata_m0_f), .hrdata_m1(hrdata_m1_f),
    .hready_m0(hready_m0_f), .hready_m1(hready_m1_f),
    .hresp_m0(hresp_m0_f), .hresp_m1(hresp_m1_f),
    .hsel_s(hsel_s_f), .hmaster_s(hmaster_s_f),
    .haddr_s(haddr_s_f), .hsize_s(hsize_s_f),
    .hwrite_s(hwrite_s_f), .hwdata_s(hwdata_s_f),
    .hrdata_s(hrdata_s), .hready_s(hready_s),
    .hresp_s(hresp_s), .grant(grant_f)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_hsel"}, 32'(hsel_s), 32'h0);
    chk({tag, "_haddr"}, haddr_s, 32'h0);
    chk({tag, "_hmaster"}, hmaster_s, 32'h0);
    chk({tag, "_hwdata"}, hwdata_s, 32'h0);
    chk({tag, "_hsize"}, 32'(hsize_s), 32'h0);
    chk({tag, "_hwrite"}, 32'(hwrite_s), 32'h0);
    chk({tag, "_rdy"}, 32'({hready_m1, hready_m0}), 32'h3);
    chk({tag, "_resp"}, 32'({hresp_m1, hresp_m0}), 32'h0);
    chk({tag, "_rd0"}, hrdata_m0, 32'h0);
    chk({tag, "_rd1"}, hrdata_m1, 32'h0);
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    #1;
    cyc();
    hresetn = 1'b1;
    #1;
  endtask

  task automatic tie(input int n);
    hsel_m0 = 1'b1; hsel_m1 = 1'b1;
    haddr_m0 = 32'h400 + 32'(n); haddr_m1 = 32'h300 + 32'(n);
    cyc();
    hsel_m0 = 1'b0; hsel_m1 = 1'b0;
    #1;
    chk("tie_rr_first", 32'(grant), 32'h2);
    chk("tie_fp_first", 32'(grant_f), 32'h1);
    chk("tie_rr_addr1", haddr_s, 32'h300 + 32'(n));
    cyc();
    chk("tie_rr_m0_wait", 32'(hready_m0), 32'h0);
    cyc();
    chk("tie_rr_second", 32'(grant), 32'h1);
    chk("tie_fp_second", 32'(grant_f), 32'h2);
    chk("tie_no_idle", 32'(hsel_s), 32'h1);
    chk("tie_rr_addr2", haddr_s, 32'h400 + 32'(n));
    cyc();
    cyc();
    chk("tie_idle", 32'(grant), 32'h0);
  endtask

  initial begin
    hresetn = 1'b0;
    hsel_m0 = 0; hsel_m1 = 0;
    hmaster_m0 = 32'h0; hmaster_m1 = 32'h1;
    haddr_m0 = 0; haddr_m1 = 0;
    hsize_m0 = 3'd2; hsize_m1 = 3'd2;
    hwrite_m0 = 0; hwrite_m1 = 0;
    hwdata_m0 = 0; hwdata_m1 = 0;
    hrdata_s = 0; hready_s = 1'b1; hresp_s = 1'b0;
    cyc(); cyc();
    chk_reset_outs("rst");
    hresetn = 1'b1;
    cyc();

    // single read by m0
    hsel_m0 = 1'b1; haddr_m0 = 32'h100;
    #1;
    chk("rd_rdy_before", 32'(hready_m0), 32'h1);
    cyc();
    hsel_m0 = 1'b0;
    #1;
    chk("rd_hsel_t1", 32'(hsel_s), 32'h1);
    chk("rd_addr_t1", haddr_s, 32'h100);
    chk("rd_grant_t1", 32'(grant), 32'h1);
    chk("rd_hsize_t1", 32'(hsize_s), 32'h2);
    chk("rd_rdy_t1", 32'(hready_m0), 32'h0);
    cyc();
    hrdata_s = 32'hA5A5A5A5;
    #1;
    chk("rd_hsel_t2", 32'(hsel_s), 32'h0);
    chk("rd_data_t2", hrdata_m0, 32'hA5A5A5A5);
    chk("rd_rdy_t2", 32'(hready_m0), 32'h1);
    chk("rd_other_data", hrdata_m1, 32'h0);
    cyc();
    hrdata_s = 32'h0;
    chk("rd_idle_grant", 32'(grant), 32'h0);

    // ties: RR alternates from reset, FP always m0 first
    do_reset();
    for (int i = 0; i < 3; i++) tie(i);

    // m1 write with three wait states, m0 arrives mid-transfer
    hsel_m1 = 1'b1; haddr_m1 = 32'h200; hwrite_m1 = 1'b1;
    cyc();
    hsel_m1 = 1'b0; hwrite_m1 = 1'b0; hwdata_m1 = 32'hDEADBEEF;
    hsel_m0 = 1'b1; haddr_m0 = 32'h500;
    #1;
    chk("ws_grant", 32'(grant), 32'h2);
    chk("ws_hwrite", 32'(hwrite_s), 32'h1);
    chk("ws_addr", haddr_s, 32'h200);
    cyc();
    hsel_m0 = 1'b0; hready_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_hwdata", hwdata_s, 32'hDEADBEEF);
      chk("ws_rdy_m1", 32'(hready_m1), 32'h0);
      chk("ws_rdy_m0", 32'(hready_m0), 32'h0);
      chk("ws_hold_grant", 32'(grant), 32'h2);
      chk("ws_hold_addr", haddr_s, 32'h200);
      cyc();
    end
    hready_s = 1'b1;
    #1;
    chk("ws_done_m1", 32'(hready_m1), 32'h1);
    cyc();
    chk("ws_m0_grant", 32'(grant), 32'h1);
    chk("ws_m0_grant_fp", 32'(grant_f), 32'h1);
    chk("ws_m0_addr", haddr_s, 32'h500);
    cyc();
    chk("ws_m0_wdata_zero", hwdata_s, 32'h0);
    cyc();
    chk("ws_idle", 32'(grant), 32'h0);

    // error response passthrough
    hsel_m0 = 1'b1; haddr_m0 = 32'h700;
    cyc();
    hsel_m0 = 1'b0;
    cyc();
    hresp_s = 1'b1; hready_s = 1'b0;
    #1;
    chk("err1_resp_m0", 32'(hresp_m0), 32'h1);
    chk("err1_rdy_m0", 32'(hready_m0), 32'h0);
    chk("err1_resp_m1", 32'(hresp_m1), 32'h0);
    cyc();
    hready_s = 1'b1;
    #1;
    chk("err2_resp_m0", 32'(hresp_m0), 32'h1);
    chk("err2_rdy_m0", 32'(hready_m0), 32'h1);
    chk("err2_resp_m1", 32'(hresp_m1), 32'h0);
    cyc();
    hresp_s = 1'b0;
    #1;
    chk("err_idle_resp", 32'(hresp_m0), 32'h0);

    // back-to-back request captured on completion cycle
    hsel_m0 = 1'b1; haddr_m0 = 32'h800;
    cyc();
    hsel_m0 = 1'b0;
    cyc();
    hsel_m0 = 1'b1; haddr_m0 = 32'h900;
    #1;
    chk("b2b_rdy_done", 32'(hready_m0), 32'h1);
    cyc();
    hsel_m0 = 1'b0;
    #1;
    chk("b2b_idle_grant", 32'(grant), 32'h0);
    chk("b2b_pending", 32'(hready_m0), 32'h0);
    cyc();
    chk("b2b_addr2", haddr_s, 32'h900);
    chk("b2b_grant2", 32'(grant), 32'h1);
    cyc(); cyc();

    // reset in DATA abandons the transfer
    hsel_m1 = 1'b1; haddr_m1 = 32'hA00; hwdata_m1 = 32'h12345678;
    cyc();
    hsel_m1 = 1'b0;
    cyc();
    hready_s = 1'b0; hresp_s = 1'b1; hrdata_s = 32'hFFFF0000;
    #1;
    chk("rstd_in_data", 32'(grant), 32'h2);
    #2;
    hresetn = 1'b0;
    #1;
    chk_reset_outs("rstd");
    cyc();
    hresetn = 1'b1;
    hready_s = 1'b1; hresp_s = 1'b0; hrdata_s = 32'h0;
    cyc();
    chk("rstd_after_grant", 32'(grant), 32'h0);
    chk("rstd_after_hsel", 32'(hsel_s), 32'h0);
    chk("rstd_after_rdy", 32'(hready_m1), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with master 0 highest.
REQ-002 The block SHALL have port hclk, in, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port hresetn, in, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports hsel_m0 / hsel_m1, in, 1: transfer request from master 0 / 1, non-sequential only.
REQ-005 The block SHALL have ports hmaster_m0 / hmaster_m1, in, 32: master ID.
REQ-006 The block SHALL have ports haddr_m0 / haddr_m1, in, 32: transaction address.
REQ-007 The block SHALL have ports hsize_m0 / hsize_m1, in, 3: byte, half-word or word size.
REQ-008 The block SHALL have ports hwrite_m0 / hwrite_m1, in, 1: write control.
REQ-009 The block SHALL have ports hwdata_m0 / hwdata_m1, in, 32: write data, valid in that master's data phase.
REQ-010 The block SHALL have ports hrdata_m0 / hrdata_m1, out, 32: read data.
REQ-011 The block SHALL have ports hready_m0 / hready_m1, out, 1: stall signal.
REQ-012 The block SHALL have ports hresp_m0 / hresp_m1, out, 1: error response.
REQ-013 The block SHALL have slave-side outputs hsel_s (1), hmaster_s (32), haddr_s (32), hsize_s (3), hwrite_s (1) and hwdata_s (32).
REQ-014 The block SHALL have slave-side inputs hrdata_s (32), hready_s (1) and hresp_s (1).
REQ-015 The block SHALL have port grant, out, 2: one-hot owner of the slave port; 00 when idle.

Function
REQ-016 Master i SHALL have a request captured into its pending buffer (hmaster, haddr, hsize, hwrite) on a rising edge where hsel_mi=1 and hready_mi=1.
REQ-017 Each pending buffer SHALL hold exactly one request, and hready_mi SHALL be 0 from the cycle after capture until that request completes.
REQ-018 The FSM SHALL have three states: IDLE, ADDR and DATA.
REQ-019 FSM transitions SHALL be: IDLE->ADDR when any buffer is pending; ADDR->DATA unconditionally; DATA->ADDR when hready_s=1 and another buffer is pending; DATA->IDLE when hready_s=1 and none is pending; DATA stays in DATA while hready_s=0.
REQ-020 The winner SHALL be chosen on entry to ADDR.
REQ-021 With one request pending, that master SHALL win.
REQ-022 With both pending and RR_EN=1, the master not granted last SHALL win; after reset, master 0 is treated as granted last, so master 1 wins the first tie.
REQ-023 With both pending and RR_EN=0, master 0 SHALL win.
REQ-024 In ADDR, the block SHALL drive hsel_s=1 and haddr_s, hsize_s, hwrite_s, hmaster_s from the winner's buffer; grant SHALL be one-hot for the winner.
REQ-025 In DATA, the block SHALL drive hsel_s=0, hold the address outputs, and set hwdata_s = hwdata of the granted master.
REQ-026 In DATA, hready_mi, hresp_mi and hrdata_mi of the granted master SHALL equal hready_s, hresp_s and hrdata_s combinationally; the two-cycle error response passes through unchanged.
REQ-027 The pending buffer of the granted master SHALL clear on the DATA edge where hready_s=1.
REQ-028 A new request from the same master presented in that same completion cycle SHALL be captured.
REQ-029 A non-granted master SHALL see hresp_mi=0 and hrdata_mi=0; its hready_mi SHALL be 1 if nothing is pending for it, else 0.
REQ-030 In IDLE, hsel_s SHALL be 0 and hwdata_s SHALL be 0.
REQ-031 Minimum latency SHALL be: capture at edge T, ADDR in cycle T+1, DATA in cycle T+2; hready_mi=1 in T+2 when hready_s=1.
REQ-032 A request arriving while the other master's transfer is in DATA SHALL wait until that transfer completes; the slave port SHALL never be preempted mid-transfer.
REQ-033 Simultaneous capture from both masters in IDLE SHALL resolve per REQ-022/REQ-023; the loser SHALL be served immediately after, with no IDLE cycle between.

Reset
REQ-034 On hresetn=0, asynchronously: FSM=IDLE, both buffers cleared, last-grant=master 0.
REQ-035 While in reset, outputs SHALL be: grant=00, hsel_s=0, hmaster_s/haddr_s/hwdata_s=0, hsize_s=0, hwrite_s=0, hready_m0/m1=1, hresp_m0/m1=0, hrdata_m0/m1=0.
REQ-036 Reset asserted mid-transfer SHALL abandon the transfer with no completion signalled to any master.

Verification
REQ-037 Single read: m0 reads 0x100 and the slave returns 0xA5A5A5A5 with hready_s=1 -> hsel_s=1 in T+1, hrdata_m0=0xA5A5A5A5 and hready_m0=1 in T+2.
REQ-038 Tie, RR_EN=1: both masters request in the same cycle after reset -> grant sequence 10 then 01, back-to-back with no IDLE; a second tie -> 10 then 01 again.
REQ-039 Tie, RR_EN=0: three consecutive ties -> m0 served first every time.
REQ-040 Wait states: m1 writes 0xDEADBEEF to 0x200 and hready_s is held 0 for 3 DATA cycles -> hwdata_s=0xDEADBEEF stable across those cycles, hready_m1=0 throughout; m0 requesting meanwhile is not granted until m1 completes.
REQ-041 Error: slave gives hresp_s=1 with hready_s=0 then 1 -> the granted master sees an identical two-cycle error; the other master sees hresp=0.
REQ-042 Reset in DATA: hresetn pulsed low for 1 cycle -> all outputs at REQ-035 values immediately, FSM in IDLE, grant=00.
